// File: rtl/fir_decim_out_if.sv
// Valid/ready sample stream from the FIR output stage toward the DAC/serializer.
interface fir_decim_out_if #(
  parameter int OUT_WIDTH = 16
);
  logic signed [OUT_WIDTH-1:0] data;
  logic                        valid;
  logic                        ready;

  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/fir_decim_out.sv
// Output stage for the 128-tap sequential FIR: frame tracking, start-up skip,
// decimation, round/saturate to OUT_WIDTH and a first-word-fall-through FIFO.
module fir_decim_out #(
  parameter int WIDTH     = 24,
  parameter int OUT_WIDTH = 16,
  parameter int FRAME     = 128,
  parameter int DECIM     = 4,
  parameter int SKIP      = 1,
  parameter int DEPTH     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fir_ready,
  input  logic signed [WIDTH-1:0]      fir_sig,
  fir_decim_out_if.master              m,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         clip,
  output logic                         overrun,
  input  logic                         clr_ovr
);

  localparam int SH  = WIDTH - OUT_WIDTH;
  localparam int PW  = $clog2(FRAME);
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int SKW = (SKIP < 1) ? 1 : $clog2(SKIP + 1);
  localparam int DCW = (DECIM < 2) ? 1 : $clog2(DECIM);

  localparam logic signed [WIDTH:0] HALF = (WIDTH+1)'(2 ** (SH - 1));
  localparam logic signed [WIDTH:0] MAXV = (WIDTH+1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [WIDTH:0] MINV = (WIDTH+1)'(-(2 ** (OUT_WIDTH - 1)));

  // ---------------- frame phase, mirrors the FIR tap index ----------------
  logic [PW-1:0] ph;
  logic          cap_pend;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph       <= PW'(FRAME - 1);
      cap_pend <= 1'b0;
    end else begin
      cap_pend <= fir_ready && (ph == PW'(FRAME - 1));
      if (fir_ready) ph <= ph + 1'b1;  // FRAME is a power of 2, so this wraps to 0
    end
  end

  // ---------------- skip / decimation ----------------
  logic [SKW-1:0] skip_cnt;
  logic [DCW-1:0] dcnt;
  logic           keep;

  assign keep = cap_pend && (skip_cnt == '0) && (dcnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt <= SKW'(SKIP);
      dcnt     <= '0;
    end else if (cap_pend) begin
      if (skip_cnt != '0) skip_cnt <= skip_cnt - 1'b1;
      else                dcnt     <= (dcnt == DCW'(DECIM - 1)) ? '0 : dcnt + 1'b1;
    end
  end

  // ---------------- round half-up, then saturate ----------------
  logic signed [WIDTH:0]       ext;
  logic signed [WIDTH:0]       shr;
  logic signed [OUT_WIDTH-1:0] rnd;
  logic                        sat;

  // NOTE: every combinational output gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    ext = $signed({fir_sig[WIDTH-1], fir_sig}) + HALF;
    shr = ext >>> SH;
    rnd = shr[OUT_WIDTH-1:0];
    sat = 1'b0;
    if (shr > MAXV) begin
      rnd = MAXV[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (shr < MINV) begin
      rnd = MINV[OUT_WIDTH-1:0];
      sat = 1'b1;
    end
  end

  logic                        stg_vld;
  logic                        stg_sat;
  logic signed [OUT_WIDTH-1:0] stg_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld  <= 1'b0;
      stg_sat  <= 1'b0;
      stg_data <= '0;
    end else begin
      stg_vld <= keep;
      if (keep) begin
        stg_data <= rnd;
        stg_sat  <= sat;
      end
    end
  end

  // ---------------- FIFO ----------------
  logic signed [OUT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]               rd_ptr;
  logic [AW-1:0]               wr_ptr;
  logic signed [OUT_WIDTH-1:0] head;
  logic signed [OUT_WIDTH-1:0] head_nx;
  logic                        empty;
  logic                        full;
  logic                        pop;
  logic                        push;
  logic                        drop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop     = !empty && m.ready;
  assign push    = stg_vld && (!full || pop);
  assign drop    = stg_vld && full && !pop;
  assign m.valid = !empty;
  assign m.data  = head;

  // The head register holds the last word once the FIFO drains.
  always_comb begin
    head_nx = head;
    if (push && (empty || (pop && level == LW'(1)))) head_nx = stg_data;
    else if (pop && level != LW'(1))                  head_nx = mem[rd_ptr + 1'b1];
  end

  // NOTE: the storage array has no reset; only pointers and level define
  // which words are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= stg_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
      head    <= '0;
      clip    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      head    <= head_nx;
      clip    <= stg_vld && stg_sat;
      overrun <= (overrun && !clr_ovr) || drop;
    end
  end

endmodule

// File: tb/tb_fir_decim_out.sv
// Randomized bench for fir_decim_out against a queue-based reference built
// from enabled-cycle counting, capture indices and integer floor division.
module tb_fir_decim_out;

  localparam int WIDTH     = 24;
  localparam int OUT_WIDTH = 16;
  localparam int FRAME     = 128;
  localparam int DECIM     = 4;
  localparam int SKIP      = 1;
  localparam int DEPTH     = 8;
  localparam int SH        = WIDTH - OUT_WIDTH;
  localparam int LW        = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    fir_ready = 1'b0;
  logic                    clr_ovr = 1'b0;
  logic signed [WIDTH-1:0] fir_sig = '0;
  logic [LW-1:0]           level;
  logic                    clip;
  logic                    overrun;

  fir_decim_out_if #(.OUT_WIDTH(OUT_WIDTH)) m_if ();

  fir_decim_out #(
    .WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH), .FRAME(FRAME),
    .DECIM(DECIM), .SKIP(SKIP), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fir_ready(fir_ready), .fir_sig(fir_sig),
    .m(m_if), .level(level), .clip(clip), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int en_cnt, cap_idx, stg_d_m, head_m;
  bit cap_pend_m, stg_v_m, stg_s_m, ovr_m, clip_m;
  int q[$];
  int want[$];     // values presented on kept captures, in order
  int dir_exp[$];  // expected words at the stream, in order
  bit dir_on = 0;
  int dut_clips = 0;
  int ramp_val = 0;

  function automatic bit keeper(input int idx);
    return (idx >= SKIP) && (((idx - SKIP) % DECIM) == 0);
  endfunction

  function automatic int scale(input int x, output bit s);
    int v, r;
    v = x + 2 ** (SH - 1);
    r = (v >= 0) ? v / (2 ** SH) : -((-v + 2 ** SH - 1) / (2 ** SH));
    s = 1'b0;
    if (r > 2 ** (OUT_WIDTH - 1) - 1) begin
      r = 2 ** (OUT_WIDTH - 1) - 1;
      s = 1'b1;
    end else if (r < -(2 ** (OUT_WIDTH - 1))) begin
      r = -(2 ** (OUT_WIDTH - 1));
      s = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    en_cnt = 0; cap_idx = 0; cap_pend_m = 0;
    stg_v_m = 0; stg_s_m = 0; stg_d_m = 0;
    q.delete(); ovr_m = 0; clip_m = 0; head_m = 0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    bit pop, drop, s;
    int idx;
    pop  = (q.size() != 0) && m_if.ready;
    drop = 0;
    if (pop) void'(q.pop_front());
    if (stg_v_m) begin
      if (q.size() < DEPTH) q.push_back(stg_d_m);
      else drop = 1;
    end
    clip_m = stg_v_m && stg_s_m;
    if (clr_ovr) ovr_m = 0;
    if (drop) ovr_m = 1;
    if (q.size() != 0) head_m = q[0];
    stg_v_m = 0;
    if (cap_pend_m) begin
      idx = cap_idx;
      cap_idx++;
      if (keeper(idx)) begin
        stg_d_m = scale(int'(fir_sig), s);
        stg_s_m = s;
        stg_v_m = 1;
      end
    end
    cap_pend_m = fir_ready && ((en_cnt % FRAME) == 0);
    if (fir_ready) en_cnt++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("m_valid", m_if.valid, q.size() != 0);
    check("level", level, q.size());
    check("m_data", $signed(m_if.data), head_m);
    check("clip", clip, clip_m);
    check("overrun", overrun, ovr_m);
    if (clip) dut_clips++;
  endtask

  task automatic drive(input bit fr, input bit mr, input bit co, input bit ramp);
    fir_ready  = fr;
    m_if.ready = mr;
    clr_ovr    = co;
    if (cap_pend_m && keeper(cap_idx) && want.size() != 0) fir_sig = WIDTH'(want.pop_front());
    else if (ramp) fir_sig = WIDTH'(ramp_val);
    else fir_sig = WIDTH'($urandom);
    ramp_val += 1237;
    if (dir_on && mr && m_if.valid && dir_exp.size() != 0)
      check("stream order", $signed(m_if.data), dir_exp.pop_front());
    step();
  endtask

  // Run with fir_ready=1 until every queued value has reached the FIFO.
  // pp: raise m_ready only on edges that push into a full FIFO.
  task automatic run_until_fed(input bit mr, input bit pp, input int limit);
    int n;
    bit r;
    n = 0;
    while ((want.size() != 0 || cap_pend_m || stg_v_m) && n < limit) begin
      r = pp ? ((q.size() == DEPTH) && stg_v_m) : mr;
      drive(1, r, 0, 0);
      n++;
    end
    check("feed within budget", n < limit, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst m_valid", m_if.valid, 0);
    check("rst level", level, 0);
    check("rst m_data", $signed(m_if.data), 0);
    check("rst clip", clip, 0);
    check("rst overrun", overrun, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    m_if.ready = 1'b1;
    model_reset();
    do_reset();

    // Start-up: first capture skipped, then 1 of every DECIM kept.
    for (int i = 0; i < 1300; i++) drive(1, 1, 0, 1);

    // Rounding and saturation corners.
    want    = '{'h180, 'h17F, -128, -385, 'h7FFFFF, -'h800000};
    dir_exp = '{2, 1, 0, -2, 32767, -32768};
    dir_on = 1; dut_clips = 0;
    run_until_fed(1, 0, 4000);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
    check("round words seen", dir_exp.size(), 0);
    check("clip pulses", dut_clips, 1);
    dir_on = 0;

    // Overflow: 9 kept samples into an 8-deep FIFO with no reads.
    for (int k = 1; k <= 9; k++) want.push_back(k << SH);
    run_until_fed(0, 0, 6000);
    check("ovf level", level, DEPTH);
    check("ovf overrun", overrun, 1);
    for (int k = 1; k <= 8; k++) dir_exp.push_back(k);
    dir_on = 1;
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 0);
    check("ovf drained", dir_exp.size(), 0);
    dir_on = 0;
    drive(1, 1, 1, 0);
    check("clr_ovr clears", overrun, 0);

    // Push and pop on the same edge while full.
    for (int k = 1; k <= 9; k++) want.push_back(k << SH);
    run_until_fed(0, 1, 6000);
    check("pp level", level, DEPTH);
    check("pp overrun", overrun, 0);
    for (int k = 2; k <= 9; k++) dir_exp.push_back(k);
    dir_on = 1;
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 0);
    check("pp drained", dir_exp.size(), 0);
    dir_on = 0;

    // Reset mid-frame with five words buffered, then restart.
    for (int k = 1; k <= 5; k++) want.push_back($urandom_range(0, 'hFFFFFF));
    run_until_fed(0, 0, 4000);
    for (int i = 0; i < 40; i++) drive(1, 0, 0, 0);
    check("pre-reset level", level, 5);
    do_reset();
    ramp_val = 0;
    for (int i = 0; i < 1300; i++) drive(1, 1, 0, 1);

    // Irregular enables, back-pressure and clears.
    for (int i = 0; i < 6000; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 99) == 0, 0);
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
